// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK command encodings, arbiter FSM states and index width
package jk_pkg;

    localparam int IDX_W = 4;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - single JK flip-flop with enable and synchronous active-high reset
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                JK_HOLD: q <= q;
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// rtl/jk_cmd_arbiter.sv - round-robin command arbiter with lock ownership over a JK bit bank; JK_ARB_STATS_EN adds toggle_cnt
module jk_cmd_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 16,
    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_jk,
    input  logic [IDX_W*NREQ-1:0]   req_idx,
    input  logic [NREQ-1:0]         req_lock,
    output logic [WIDTH-1:0]        q,
    output logic                    err,
    output logic [PTR_W-1:0]        owner,
    output logic                    locked
`ifdef JK_ARB_STATS_EN
    ,
    output logic [15:0]             toggle_cnt
`endif
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic [CNT_W-1:0] idle_cnt;
    logic             found;
    logic             hs;
    logic [1:0]       sel_jk;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_lock;
    logic             in_range;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        return PTR_W'((int'(w) + 1) % NREQ);
    endfunction

    // While locked only the owner can win; otherwise scan upward from rr_ptr.
    always_comb begin
        req_ready = '0;
        win       = '0;
        found     = 1'b0;
        if (!rst) begin
            if (state == ST_OWNED) begin
                if (req_valid[owner]) begin
                    found = 1'b1;
                    win   = owner;
                end
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                        found = 1'b1;
                        win   = PTR_W'((int'(rr_ptr) + i) % NREQ);
                    end
                end
            end
            if (found) begin
                req_ready[win] = 1'b1;
            end
        end
    end

    assign hs       = found;
    assign sel_jk   = req_jk[2*win +: 2];
    assign sel_idx  = req_idx[IDX_W*win +: IDX_W];
    assign sel_lock = req_lock[win];
    assign in_range = int'(sel_idx) < WIDTH;
    assign locked   = (state == ST_OWNED);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        jk_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (hs && in_range && (int'(sel_idx) == b)),
            .j   (sel_jk[1]),
            .k   (sel_jk[0]),
            .q   (q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= hs && !in_range;
            if (hs) begin
                rr_ptr <= next_ptr(win);
            end
            case (state)
                ST_IDLE: begin
                    if (hs && sel_lock) begin
                        state    <= ST_OWNED;
                        owner    <= win;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    if (hs) begin
                        idle_cnt <= '0;
                        if (!sel_lock) begin
                            state <= ST_IDLE;
                        end
                    end else if (idle_cnt == CNT_W'(LOCK_MAX - 1)) begin
                        // This idle cycle is the LOCK_MAX-th in a row: force release.
                        state    <= ST_IDLE;
                        idle_cnt <= '0;
                        rr_ptr   <= next_ptr(owner);
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef JK_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (hs && in_range && sel_jk == JK_TOG && toggle_cnt != 16'hFFFF) begin
            toggle_cnt <= toggle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// tb/tb_jk_cmd_arbiter.sv - randomized and directed bench for jk_cmd_arbiter against a behavioural model
module tb_jk_cmd_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_jk;
    logic [4*NREQ-1:0]   req_idx;
    logic [NREQ-1:0]     req_lock;
    logic [WIDTH-1:0]    q;
    logic                err;
    logic [1:0]          owner;
    logic                locked;
`ifdef JK_ARB_STATS_EN
    logic [15:0]         toggle_cnt;
`endif

    jk_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_jk    (req_jk),
        .req_idx   (req_idx),
        .req_lock  (req_lock),
        .q         (q),
        .err       (err),
        .owner     (owner),
        .locked    (locked)
`ifdef JK_ARB_STATS_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_q [WIDTH];
    int m_ptr, m_owner, m_idle, m_tog;
    bit m_locked, m_err;

    logic [NREQ-1:0]  obs_ready;
    logic [WIDTH-1:0] obs_q;
    logic             obs_locked, obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_q();
        logic [WIDTH-1:0] v;
        for (int b = 0; b < WIDTH; b++) v[b] = m_q[b];
        return v;
    endfunction

    function automatic int model_grant();
        if (rst) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < WIDTH; b++) m_q[b] = 1'b0;
        m_ptr = 0; m_owner = 0; m_idle = 0; m_tog = 0;
        m_locked = 1'b0; m_err = 1'b0;
    endtask

    // One clock: compare at negedge, then advance the model across the posedge.
    task automatic cycle();
        int g, idx;
        logic [1:0] cmd;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        g = model_grant();
        exp_ready = (g < 0) ? '0 : NREQ'(1 << g);
        obs_ready = req_ready; obs_q = q; obs_locked = locked; obs_err = err;
        check("req_ready", req_ready, exp_ready);
        check("q", q, model_q());
        check("err", err, m_err);
        check("locked", locked, m_locked);
        if (m_locked) check("owner", owner, m_owner);
`ifdef JK_ARB_STATS_EN
        check("toggle_cnt", toggle_cnt, m_tog);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (g >= 0) begin
                idx = int'(req_idx[4*g +: 4]);
                cmd = req_jk[2*g +: 2];
                if (idx < WIDTH) begin
                    if (cmd == 2'b01) m_q[idx] = 1'b0;
                    else if (cmd == 2'b10) m_q[idx] = 1'b1;
                    else if (cmd == 2'b11) begin
                        m_q[idx] = !m_q[idx];
                        if (m_tog < 65535) m_tog++;
                    end
                end else begin
                    m_err = 1'b1;
                end
                m_ptr = (g + 1) % NREQ;
                if (!m_locked && req_lock[g]) begin
                    m_locked = 1'b1; m_owner = g; m_idle = 0;
                end else if (m_locked) begin
                    m_idle = 0;
                    if (!req_lock[g]) m_locked = 1'b0;
                end
            end else if (m_locked) begin
                m_idle++;
                if (m_idle == LOCK_MAX) begin
                    m_locked = 1'b0; m_idle = 0;
                    m_ptr = (m_owner + 1) % NREQ;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input int r, input logic [1:0] cmd, input int idx, input logic lk);
        req_valid[r]       = 1'b1;
        req_jk[2*r +: 2]   = cmd;
        req_idx[4*r +: 4]  = 4'(idx);
        req_lock[r]        = lk;
    endtask

    task automatic idle_all();
        req_valid = '0; req_jk = '0; req_idx = '0; req_lock = '0;
    endtask

    logic [NREQ-1:0] seq_ready [4];
    logic            seq_q5 [4];
    int              lock_cycles;

    initial begin
        model_reset();
        idle_all();
        rst = 1'b1;
        // Command offered during reset must not be applied.
        drive(2, 2'b10, 1, 1'b1);
        cycle();
        cycle();
        idle_all();
        rst = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        check("rst_q", q, 8'h00);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err, 1'b0);
        @(posedge clk); #1;

        // Requesters 0 and 2 contend with set on bit 3.
        drive(0, 2'b10, 3, 1'b0);
        drive(2, 2'b10, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq_ready[i] = obs_ready;
        end
        check("rr_order0", seq_ready[0], 4'b0001);
        check("rr_order1", seq_ready[1], 4'b0100);
        check("rr_order2", seq_ready[2], 4'b0001);
        check("rr_order3", seq_ready[3], 4'b0100);
        check("set_bit3", obs_q[3], 1'b1);

        // Requester 1 toggles bit 5 four times.
        idle_all();
        drive(1, 2'b11, 5, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) idle_all();
            cycle();
            seq_q5[i] = obs_q[5];
        end
        check("tog5_0", seq_q5[0], 1'b1);
        check("tog5_1", seq_q5[1], 1'b0);
        check("tog5_2", seq_q5[2], 1'b1);
        check("tog5_3", seq_q5[3], 1'b0);

        // Requester 3 targets an out-of-range bit.
        drive(3, 2'b10, 9, 1'b0);
        cycle();
        idle_all();
        cycle();
        check("oor_err", obs_err, 1'b1);
        cycle();
        check("oor_err_clear", obs_err, 1'b0);

        // Requester 1 locks then goes quiet while requester 0 waits.
        drive(1, 2'b10, 0, 1'b1);
        cycle();
        idle_all();
        drive(0, 2'b10, 2, 1'b0);
        lock_cycles = 0;
        for (int i = 0; i < LOCK_MAX; i++) begin
            cycle();
            if (obs_locked) lock_cycles++;
        end
        check("lock_hold_cycles", lock_cycles, LOCK_MAX);
        cycle();
        check("post_release_grant", obs_ready, 4'b0001);
        idle_all();
        cycle();

        // Reset coincident with a lock handshake from requester 2.
        rst = 1'b1;
        drive(2, 2'b11, 4, 1'b1);
        cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        cycle();
        check("rst_lock_locked", obs_locked, 1'b0);
        check("rst_lock_q", obs_q, 8'h00);
        check("rst_lock_ptr", obs_ready, 4'b0001);
        idle_all();
        cycle();

        // Randomized segments; mode 2 starves the lock owner to exercise timeout.
        for (int seg = 0; seg < 60; seg++) begin
            int mode, len;
            mode = $urandom_range(0, 2);
            len  = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 99) == 0);
                for (int r = 0; r < NREQ; r++) begin
                    req_valid[r]      = ($urandom_range(0, 2) != 0);
                    req_jk[2*r +: 2]  = 2'($urandom_range(0, 3));
                    req_idx[4*r +: 4] = 4'($urandom_range(0, 11));
                    req_lock[r]       = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
                end
                if (mode == 2 && m_locked) req_valid[m_owner] = 1'b0;
                cycle();
            end
        end
        rst = 1'b0;
        idle_all();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter WIDTH, default 8: number of JK flip-flop bits in the shared bank.
REQ-003 Parameter LOCK_MAX, default 16: maximum idle cycles an owned lock is held before forced release.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
REQ-005 Ports SHALL be:
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  one-hot grant; a handshake occurs where valid and ready are both 1.
- req_jk  in  2*NREQ  per-requester {j,k} command; requester r uses bits [2r+1:2r].
- req_idx  in  4*NREQ  per-requester target bit index; requester r uses bits [4r+3:4r].
- req_lock  in  NREQ  keep ownership after this handshake.
- q  out  WIDTH  JK bank state.
- err  out  1  one-cycle pulse on an out-of-range index.
- owner  out  clog2(NREQ)  current lock owner; valid only while locked is 1.
- locked  out  1  the FSM is in OWNED.

Function
REQ-006 At most one req_ready bit SHALL be 1 per cycle, and only for a requester with req_valid=1.
REQ-007 req_ready SHALL be combinational from req_valid, the round-robin pointer and the FSM state.
REQ-008 In IDLE, the winner SHALL be the first valid requester searching upward from rr_ptr, wrapping NREQ-1→0.
REQ-009 After a handshake by requester w, rr_ptr SHALL become (w+1) mod NREQ at the next edge; with no handshake, rr_ptr SHALL be unchanged.
REQ-010 A handshaken command SHALL update q[idx] at the next rising edge, one-cycle latency, as follows:
- 00: hold.
- 01: clear.
- 10: set.
- 11: toggle.
REQ-011 All other q bits SHALL be unchanged.
REQ-012 If idx >= WIDTH, the handshake SHALL still complete, q SHALL be unchanged, and err SHALL be 1 for exactly the following cycle.
REQ-013 FSM states: IDLE and OWNED.
- IDLE→OWNED on a handshake with req_lock=1; owner latches the winner.
- In OWNED, only the owner may be granted, and other requesters stall.
- OWNED→IDLE on an owner handshake with req_lock=0.
- OWNED→IDLE when the owner has no handshake for LOCK_MAX consecutive cycles.
REQ-014 The idle counter SHALL clear on every owner handshake and on entry to OWNED.
REQ-015 An owner handshake with req_lock=1 SHALL keep OWNED.
REQ-016 On lock release, rr_ptr SHALL be (owner+1) mod NREQ.
REQ-017 On the timeout cycle, req_ready SHALL be 0 for all requesters; arbitration resumes from IDLE in the next cycle.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL set:
- q to 0.
- rr_ptr to 0.
- The FSM to IDLE, with locked=0 and owner=0.
- The idle counter to 0.
- err to 0.
REQ-019 req_ready SHALL be 0 during any cycle in which rst=1.
REQ-020 A command presented in a reset cycle SHALL NOT be applied.
REQ-021 Reset SHALL take priority over a concurrent handshake, lock or timeout.

Configuration
REQ-022 With JK_ARB_STATS_EN defined, the block SHALL add output toggle_cnt (16 bits).
REQ-023 toggle_cnt SHALL count applied in-range 11 commands, saturating at 16'hFFFF, and reset to 0.
REQ-024 Without JK_ARB_STATS_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package jk_pkg SHALL hold:
- The command encodings JK_HOLD, JK_CLR, JK_SET, JK_TOG.
- The FSM state typedef.
- The index width constant IDX_W=4.
REQ-026 Each bank bit SHALL be an instance of sub-module jk_ff_cell.
- Ports: clk, rst, en, j, k, q.
- When en=1, it applies the JK table; when en=0, it holds.
- Synchronous active-high reset to 0.

Verification
REQ-027 Reset release with all valid low → after 3 cycles, q=8'h00, req_ready=0, locked=0, err=0.
REQ-028 Requesters 0 and 2 each issue {10, idx 3} continuously from rr_ptr=0 → grants in the order 0,2,0,2, and q[3]=1 one cycle after the first grant.
REQ-029 Requester 1 issues 11 to idx 5 four times → q[5] sequence 1,0,1,0; with JK_ARB_STATS_EN, toggle_cnt=4.
REQ-030 Requester 3 issues idx 9 with command 10 → handshake completes, q unchanged, err=1 for one cycle.
REQ-031 Requester 1 handshakes with req_lock=1, then goes idle while requester 0 is valid → requester 0 stalls.
- locked=1 and owner=1 for 16 cycles.
- Then release; requester 0 is granted in the next cycle.
REQ-032 rst asserted in the same cycle as a lock handshake from requester 2 → q is unchanged from its reset value, locked=0, and rr_ptr=0.
